// File: rtl/game_state_tx_pkg.sv
// Shared frame definitions for the game-state link (transmitter and peer receiver).
package game_state_tx_pkg;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         FRAME_BYTES   = 7;
    localparam int         BITS_PER_BYTE = 10;

    localparam logic [2:0] B_SYNC  = 3'd0;
    localparam logic [2:0] B_SCORE = 3'd1;
    localparam logic [2:0] B_FLAGS = 3'd2;
    localparam logic [2:0] B_XHI   = 3'd3;
    localparam logic [2:0] B_XYMID = 3'd4;
    localparam logic [2:0] B_YLO   = 3'd5;
    localparam logic [2:0] B_CSUM  = 3'd6;

    // Bit positions inside B_FLAGS; the low nibble is reserved as zero.
    localparam int FLAG_ENDGAME = 7;
    localparam int FLAG_WHISTLE = 6;
    localparam int FLAG_THIRD   = 5;
    localparam int FLAG_POINT   = 4;

    typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;

    function automatic logic [7:0] frame_csum(input logic [7:0] b1, input logic [7:0] b2,
                                              input logic [7:0] b3, input logic [7:0] b4,
                                              input logic [7:0] b5);
        return b1 ^ b2 ^ b3 ^ b4 ^ b5;
    endfunction

endpackage

// File: rtl/game_state_tx_if.sv
// Judge/ball state in, serial line and frame status out.
interface game_state_tx_if;
    logic        send_req;
    logic [3:0]  score_player1;
    logic [3:0]  score_player2;
    logic        flag_point;
    logic        thirdtouched;
    logic        whistle;
    logic        endgame;
    logic [11:0] xposball;
    logic [11:0] yposball;
    logic        tx;
    logic        busy;
    logic        frame_done;

    modport master (
        output send_req, score_player1, score_player2, flag_point, thirdtouched,
               whistle, endgame, xposball, yposball,
        input  tx, busy, frame_done
    );

    modport slave (
        input  send_req, score_player1, score_player2, flag_point, thirdtouched,
               whistle, endgame, xposball, yposball,
        output tx, busy, frame_done
    );
endinterface

// File: rtl/game_state_tx_uart.sv
// One 8N1 byte onto a registered tx line; start accepted when ready, and ready
// includes the last stop-bit cycle so bytes can be chained with no gap.
module uart_tx_byte
    import game_state_tx_pkg::*;
#(
    parameter int BAUD_DIV = 564
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       done
);
    localparam int CNT_W = $clog2(BAUD_DIV);

    logic             active;
    logic [3:0]       bit_idx;
    logic [CNT_W-1:0] baud_cnt;
    logic [9:0]       shreg;

    assign done  = active && (bit_idx == 4'(BITS_PER_BYTE - 1))
                          && (baud_cnt == CNT_W'(BAUD_DIV - 1));
    assign ready = !active || done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            shreg    <= '1;
            tx       <= 1'b1;
        end else if (start && ready) begin
            active   <= 1'b1;
            bit_idx  <= '0;
            baud_cnt <= '0;
            shreg    <= {1'b1, data, 1'b0};
            tx       <= 1'b0;
        end else if (active) begin
            if (baud_cnt == CNT_W'(BAUD_DIV - 1)) begin
                baud_cnt <= '0;
                if (bit_idx == 4'(BITS_PER_BYTE - 1)) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    // Line always shows shreg[0]; shifting exposes the next bit.
                    bit_idx <= bit_idx + 4'd1;
                    shreg   <= {1'b1, shreg[9:1]};
                    tx      <= shreg[1];
                end
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/game_state_tx.sv
// Snapshots judge/ball state on send_req and sends it as a 7-byte UART frame.
// Frame lasts 70*BAUD_DIV cycles; requests while busy are dropped, whistles are held over.
module game_state_tx #(
    parameter int         BAUD_DIV  = 564,
    parameter logic [7:0] SYNC_BYTE = game_state_tx_pkg::SYNC_BYTE
) (
    input  logic            clk,
    input  logic            rst,
    game_state_tx_if.slave  gs
);
    import game_state_tx_pkg::*;

    tx_state_t                   state_q, state_n;
    logic [FRAME_BYTES-1:0][7:0] frame_q;
    logic [2:0]                  byte_idx_q, byte_idx_n;
    logic                        whistle_pend;
    logic                        load, byte_start, byte_rdy, byte_done;
    logic [7:0]                  byte_dat;
    logic                        busy_q, frame_done_q;
    logic [7:0]                  s_score, s_flags, s_xhi, s_xymid, s_ylo;

    always_comb begin
        s_score                = {gs.score_player1, gs.score_player2};
        s_flags                = 8'h00;
        s_flags[FLAG_ENDGAME]  = gs.endgame;
        s_flags[FLAG_WHISTLE]  = whistle_pend | gs.whistle;
        s_flags[FLAG_THIRD]    = gs.thirdtouched;
        s_flags[FLAG_POINT]    = gs.flag_point;
        s_xhi                  = gs.xposball[11:4];
        s_xymid                = {gs.xposball[3:0], gs.yposball[11:8]};
        s_ylo                  = gs.yposball[7:0];
    end

    always_comb begin
        state_n    = state_q;
        byte_idx_n = byte_idx_q;
        load       = 1'b0;
        byte_start = 1'b0;
        byte_dat   = SYNC_BYTE;
        case (state_q)
            IDLE, DONE: begin
                state_n = IDLE;
                // The sync byte is a constant, so it can go out on the snapshot edge itself.
                if (gs.send_req && byte_rdy) begin
                    load       = 1'b1;
                    byte_start = 1'b1;
                    byte_idx_n = B_SYNC;
                    state_n    = SEND;
                end
            end
            SEND: begin
                if (byte_done) begin
                    if (byte_idx_q == B_CSUM) begin
                        state_n = DONE;
                    end else begin
                        byte_idx_n = byte_idx_q + 3'd1;
                        byte_start = 1'b1;
                        byte_dat   = frame_q[byte_idx_n];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            frame_q      <= '0;
            whistle_pend <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            byte_idx_q   <= byte_idx_n;
            busy_q       <= (state_n == SEND);
            frame_done_q <= (state_n == DONE);
            whistle_pend <= load ? 1'b0 : (whistle_pend | gs.whistle);
            if (load) begin
                frame_q <= {frame_csum(s_score, s_flags, s_xhi, s_xymid, s_ylo),
                            s_ylo, s_xymid, s_xhi, s_flags, s_score, SYNC_BYTE};
            end
        end
    end

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
        .clk   (clk),
        .rst   (rst),
        .start (byte_start),
        .data  (byte_dat),
        .tx    (gs.tx),
        .ready (byte_rdy),
        .done  (byte_done)
    );

    assign gs.busy       = busy_q;
    assign gs.frame_done = frame_done_q;
endmodule

// File: tb/tb_game_state_tx.sv
// Directed bench for game_state_tx at BAUD_DIV=4 with a UART receiver model.
module tb_game_state_tx;
    localparam int BD = 4;
    typedef logic [6:0][7:0] frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    game_state_tx_if gif();

    game_state_tx #(.BAUD_DIV(BD)) dut (.clk(clk), .rst(rst), .gs(gif));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Receiver model: start detected on first low sample, each bit sampled mid-cell.
    logic [7:0] rxq[$];
    logic [7:0] rx_sh = '0;
    int  rx_cnt = 0, rx_err = 0;
    bit  rx_act = 0;
    always @(negedge clk) begin
        if (rst) begin
            rx_act <= 0;
        end else if (!rx_act) begin
            if (gif.tx === 1'b0) begin
                rx_act <= 1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt == 2 && gif.tx !== 1'b0) rx_err <= rx_err + 1;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt - 2) % 4 == 0)
                rx_sh[(rx_cnt - 6) / 4] <= gif.tx;
            if (rx_cnt == 38) begin
                if (gif.tx !== 1'b1) rx_err <= rx_err + 1;
                rxq.push_back(rx_sh);
                rx_act <= 0;
            end
        end
    end

    // Busy-run length, idle gap before each run, and frame_done pulse count.
    int run_cnt = 0, last_run = 0, idle_cnt = 0, last_gap = 0, fd_cnt = 0;
    bit busy_d = 0;
    always @(negedge clk) begin
        if (gif.busy === 1'b1) begin
            run_cnt  <= run_cnt + 1;
            idle_cnt <= 0;
            if (!busy_d) last_gap <= idle_cnt;
        end else begin
            idle_cnt <= idle_cnt + 1;
            if (busy_d) begin
                last_run <= run_cnt;
                run_cnt  <= 0;
            end
        end
        busy_d <= (gif.busy === 1'b1);
        if (gif.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t fr(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
        return {b6, b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic frame_t model(input logic [3:0] s1, s2, input logic fp, tt, eg, wh,
                                     input logic [11:0] x, y);
        logic [7:0] b1, b2, b3, b4, b5;
        b1 = {s1, s2};
        b2 = {eg, wh, tt, fp, 4'b0000};
        b3 = x[11:4];
        b4 = {x[3:0], y[11:8]};
        b5 = y[7:0];
        return fr(8'hA5, b1, b2, b3, b4, b5, b1 ^ b2 ^ b3 ^ b4 ^ b5);
    endfunction

    task automatic set_in(input logic [3:0] s1, s2, input logic fp, tt, eg,
                          input logic [11:0] x, y);
        gif.score_player1 = s1;
        gif.score_player2 = s2;
        gif.flag_point    = fp;
        gif.thirdtouched  = tt;
        gif.endgame       = eg;
        gif.xposball      = x;
        gif.yposball      = y;
    endtask

    task automatic pulse_req(input logic wh);
        gif.send_req = 1'b1;
        gif.whistle  = wh;
        @(posedge clk); #1;
        gif.send_req = 1'b0;
        gif.whistle  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (gif.frame_done === 1'b1) seen = 1;
        end
        #1;
        chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    endtask

    task automatic check_frame(input frame_t exp, input string tag);
        logic [7:0] got;
        chk({tag, "_nbytes"}, rxq.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
            chk($sformatf("%s_B%0d", tag, i), {24'b0, got}, {24'b0, exp[i]});
        end
        rxq.delete();
    endtask

    initial begin
        frame_t exp;
        int     fd0;
        gif.send_req = 1'b0;
        gif.whistle  = 1'b0;
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0);

        // Reset state, both during and after reset
        @(negedge clk);
        chk("rst_tx", {31'b0, gif.tx}, 32'd1);
        chk("rst_busy", {31'b0, gif.busy}, 32'd0);
        chk("rst_fd", {31'b0, gif.frame_done}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_tx", {31'b0, gif.tx}, 32'd1);
        chk("idle_busy", {31'b0, gif.busy}, 32'd0);

        // 1: basic frame A5 37 50 1F 42 EE D4, 280 busy cycles, one done pulse
        set_in(4'd3, 4'd7, 1'b1, 1'b0, 1'b0, 12'd500, 12'd750);
        fd0 = fd_cnt;
        pulse_req(1'b1);
        @(negedge clk);
        chk("t1_busy_next", {31'b0, gif.busy}, 32'd1);
        chk("t1_start_bit", {31'b0, gif.tx}, 32'd0);
        wait_done("t1");
        chk("t1_busy_in_done", {31'b0, gif.busy}, 32'd0);
        chk("t1_busy_len", last_run, 32'd280);
        check_frame(fr(8'hA5, 8'h37, 8'h50, 8'h1F, 8'h42, 8'hEE, 8'hD4), "t1");
        repeat (10) @(negedge clk);
        chk("t1_fd_once", fd_cnt - fd0, 32'd1);
        chk("t1_tx_idle", {31'b0, gif.tx}, 32'd1);

        // 2: whistle mid-frame lands in the next frame only
        set_in(4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 12'h123, 12'h456);
        pulse_req(1'b0);
        repeat (100) @(negedge clk);
        gif.whistle = 1'b1;
        @(posedge clk); #1 gif.whistle = 1'b0;
        wait_done("t2a");
        check_frame(fr(8'hA5, 8'h12, 8'h20, 8'h12, 8'h34, 8'h56, 8'h42), "t2a");
        repeat (3) @(negedge clk);
        pulse_req(1'b0);
        wait_done("t2b");
        check_frame(fr(8'hA5, 8'h12, 8'h60, 8'h12, 8'h34, 8'h56, 8'h02), "t2b");
        repeat (3) @(negedge clk);
        pulse_req(1'b0);
        wait_done("t2c");
        check_frame(fr(8'hA5, 8'h12, 8'h20, 8'h12, 8'h34, 8'h56, 8'h42), "t2c");
        repeat (3) @(negedge clk);

        // 3: send_req held high, one idle cycle between frames, own snapshots
        set_in(4'd9, 4'd4, 1'b0, 1'b0, 1'b1, 12'hFFF, 12'h000);
        gif.send_req = 1'b1;
        @(posedge clk); #1;
        set_in(4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 12'h000, 12'hFFF);
        wait_done("t3a");
        check_frame(fr(8'hA5, 8'h94, 8'h80, 8'hFF, 8'hF0, 8'h00, 8'h1B), "t3a");
        @(posedge clk); #1 gif.send_req = 1'b0;
        wait_done("t3b");
        chk("t3_gap", last_gap, 32'd1);
        chk("t3_busy_len", last_run, 32'd280);
        check_frame(fr(8'hA5, 8'h00, 8'h30, 8'h00, 8'h0F, 8'hFF, 8'hC0), "t3b");
        repeat (3) @(negedge clk);

        // 4: second request mid-frame is dropped, bytes in flight unchanged
        set_in(4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 12'h0AB, 12'hCDE);
        fd0 = fd_cnt;
        pulse_req(1'b0);
        repeat (60) @(negedge clk);
        set_in(4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 12'h555, 12'hAAA);
        pulse_req(1'b0);
        wait_done("t4");
        check_frame(fr(8'hA5, 8'h55, 8'h10, 8'h0A, 8'hBC, 8'hDE, 8'h2D), "t4");
        repeat (300) @(negedge clk);
        chk("t4_no_extra_fd", fd_cnt - fd0, 32'd1);
        chk("t4_no_extra_bytes", rxq.size(), 32'd0);

        // 5: reset during B3 clears outputs and the pending whistle
        set_in(4'd3, 4'd7, 1'b1, 1'b0, 1'b0, 12'd500, 12'd750);
        pulse_req(1'b0);
        repeat (110) @(negedge clk);
        gif.whistle = 1'b1;
        @(posedge clk); #1 gif.whistle = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_tx", {31'b0, gif.tx}, 32'd1);
        chk("t5_rst_busy", {31'b0, gif.busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rxq.delete();
        fd0 = fd_cnt;
        repeat (60) @(negedge clk);
        chk("t5_quiet_busy", {31'b0, gif.busy}, 32'd0);
        chk("t5_quiet_tx", {31'b0, gif.tx}, 32'd1);
        chk("t5_quiet_bytes", rxq.size(), 32'd0);
        chk("t5_quiet_fd", fd_cnt - fd0, 32'd0);
        pulse_req(1'b0);
        wait_done("t5");
        check_frame(fr(8'hA5, 8'h37, 8'h10, 8'h1F, 8'h42, 8'hEE, 8'h94), "t5");
        repeat (3) @(negedge clk);

        // 6: random sweep through the receiver model
        for (int n = 0; n < 50; n++) begin
            logic [3:0]  s1, s2;
            logic        fp, tt, eg, wh;
            logic [11:0] x, y;
            s1 = 4'($urandom_range(0, 15));
            s2 = 4'($urandom_range(0, 15));
            fp = 1'($urandom_range(0, 1));
            tt = 1'($urandom_range(0, 1));
            eg = 1'($urandom_range(0, 1));
            wh = 1'($urandom_range(0, 1));
            x  = 12'($urandom_range(0, 4095));
            y  = 12'($urandom_range(0, 4095));
            set_in(s1, s2, fp, tt, eg, x, y);
            exp = model(s1, s2, fp, tt, eg, wh, x, y);
            pulse_req(wh);
            wait_done($sformatf("rnd%0d", n));
            check_frame(exp, $sformatf("rnd%0d", n));
            @(negedge clk);
        end
        chk("rx_framing_errors", rx_err, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
